// File: rtl/tx_feeder.sv
// ---------------------------------------------------------------------------
// tx_feeder
//   Byte FIFO that feeds a serial transmitter through a send/busy handshake.
//   Bytes are written into a DEPTH-entry circular buffer. A small FSM moves
//   the oldest byte into tx_data, pulses tx_send for one cycle, waits for the
//   transmitter to raise tx_busy, and pops the byte only after tx_busy falls
//   again. If tx_busy does not rise within TIMEOUT cycles, the same byte is
//   re-sent and the sticky timeout flag is set.
//
// Ports
//   clk_s    in   single clock, rising edge
//   rst      in   asynchronous active-high reset
//   wr_en    in   write strobe, one byte per high cycle
//   wr_data  in   [7:0] byte to enqueue
//   full     out  count == DEPTH
//   empty    out  count == 0
//   count    out  [log2(DEPTH):0] bytes held, including the one in flight
//   tx_send  out  one-cycle send request to the transmitter
//   tx_data  out  [7:0] byte presented to the transmitter
//   tx_busy  in   transmitter busy flag
//   overflow out  sticky: a write was dropped because the FIFO was full
//   timeout  out  sticky: tx_busy failed to rise within TIMEOUT cycles
//   clr_err  in   synchronous clear of overflow and timeout
// ---------------------------------------------------------------------------
module tx_feeder #(
  parameter int DEPTH   = 16,
  parameter int TIMEOUT = 4
) (
  input  logic                   clk_s,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic [7:0]             wr_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count,
  output logic                   tx_send,
  output logic [7:0]             tx_data,
  input  logic                   tx_busy,
  output logic                   overflow,
  output logic                   timeout,
  input  logic                   clr_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);
  localparam logic [7:0]    TMO_LIMIT = 8'(TIMEOUT);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SEND,
    WAIT_BUSY,
    WAIT_DONE
  } state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [7:0]      tx_data_q, tx_data_d;
  logic [7:0]      tmo_cnt_q, tmo_cnt_d;
  logic            overflow_q, overflow_d;
  logic            timeout_q, timeout_d;
  logic [7:0]      mem_q [DEPTH];

  logic            wr_accept;
  logic            wr_drop;
  logic            pop;
  logic [7:0]      tmo_inc;
  logic            tmo_hit;

  // Status reflects the registered count, i.e. the state after the last edge.
  assign full     = (count_q == FULL_CNT);
  assign empty    = (count_q == '0);
  assign count    = count_q;
  assign tx_data  = tx_data_q;
  assign overflow = overflow_q;
  assign timeout  = timeout_q;

  // A write while full is dropped even if a pop frees a slot on the same edge.
  assign wr_accept = wr_en & ~full;
  assign wr_drop   = wr_en & full;
  // The byte stays counted until the transmitter has finished with it.
  assign pop       = (state_q == WAIT_DONE) & ~tx_busy;
  assign tmo_inc   = tmo_cnt_q + 8'd1;
  assign tmo_hit   = (state_q == WAIT_BUSY) & ~tx_busy & (tmo_inc == TMO_LIMIT);

  // ---------------- FSM: state register ----------------
  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // the pre-edge values of its inputs, independent of process ordering.
  always_ff @(posedge clk_s or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // ---------------- FSM: next-state logic ----------------
  // NOTE: every combinational output is given a default first so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:      if (!empty && !tx_busy) state_d = LOAD;
      LOAD:      state_d = SEND;
      SEND:      state_d = WAIT_BUSY;
      WAIT_BUSY: begin
        if (tx_busy)      state_d = WAIT_DONE;
        else if (tmo_hit) state_d = SEND;      // retry the same byte
      end
      WAIT_DONE: if (!tx_busy) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    tx_send = (state_q == SEND);
  end

  // ---------------- Datapath next-state ----------------
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    tx_data_d  = tx_data_q;
    tmo_cnt_d  = tmo_cnt_q;
    overflow_d = overflow_q;
    timeout_d  = timeout_q;

    if (wr_accept) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)       rd_ptr_d = rd_ptr_q + AW'(1);

    unique case ({wr_accept, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    // tx_data only changes on leaving LOAD, so it is stable for the whole
    // serialisation window including timeout retries.
    if (state_q == LOAD) begin
      tx_data_d = mem_q[rd_ptr_q];
      tmo_cnt_d = '0;
    end else if (state_q == WAIT_BUSY && !tx_busy) begin
      tmo_cnt_d = tmo_hit ? 8'd0 : tmo_inc;
    end

    // A set event in the same cycle wins over clr_err.
    if (wr_drop)      overflow_d = 1'b1;
    else if (clr_err) overflow_d = 1'b0;

    if (tmo_hit)      timeout_d = 1'b1;
    else if (clr_err) timeout_d = 1'b0;
  end

  // ---------------- Datapath registers ----------------
  always_ff @(posedge clk_s or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      tx_data_q  <= 8'h00;
      tmo_cnt_q  <= 8'd0;
      overflow_q <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      tx_data_q  <= tx_data_d;
      tmo_cnt_q  <= tmo_cnt_d;
      overflow_q <= overflow_d;
      timeout_q  <= timeout_d;
    end
  end

  // NOTE: the buffer array is deliberately left without reset; count and the
  // pointers define which entries are valid, and a resettable array would
  // prevent mapping onto RAM.
  always_ff @(posedge clk_s) begin
    if (wr_accept) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule

// File: tb/tb_tx_feeder.sv
// ---------------------------------------------------------------------------
// tb_tx_feeder
//   Self-checking bench for tx_feeder (DEPTH=16, TIMEOUT=4). Directed
//   scenarios exercise the handshake timing, overflow, timeout retry,
//   simultaneous write/pop and reset; a randomized run compares the DUT with
//   a queue-based model of the FIFO driven by a behavioural transmitter.
//   Inputs change on the falling edge; outputs are sampled there as well.
// ---------------------------------------------------------------------------
module tb_tx_feeder;

  localparam int DEPTH   = 16;
  localparam int TIMEOUT = 4;

  logic       clk_s = 1'b0;
  logic       rst   = 1'b1;
  logic       wr_en = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       full;
  logic       empty;
  logic [4:0] count;
  logic       tx_send;
  logic [7:0] tx_data;
  logic       tx_busy = 1'b0;
  logic       overflow;
  logic       timeout;
  logic       clr_err = 1'b0;

  int vectors     = 0;
  int miscompares = 0;

  tx_feeder #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk_s   (clk_s),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_data (wr_data),
    .full    (full),
    .empty   (empty),
    .count   (count),
    .tx_send (tx_send),
    .tx_data (tx_data),
    .tx_busy (tx_busy),
    .overflow(overflow),
    .timeout (timeout),
    .clr_err (clr_err)
  );

  always #5 clk_s = ~clk_s;

  // Advance through one rising edge to the following falling edge.
  task automatic tick();
    @(negedge clk_s);
  endtask

  task automatic do_reset();
    rst = 1'b1; wr_en = 1'b0; clr_err = 1'b0; tx_busy = 1'b0;
    tick();
    rst = 1'b0;
    tick();
  endtask

  // Wait (bounded) for a tx_send pulse; ok=0 if it never came.
  task automatic wait_send(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (tx_send === 1'b1) begin ok = 1'b1; break; end
    end
  endtask

  // Behave as a well-mannered transmitter for one byte.
  task automatic serve_one(output logic [7:0] got, output bit ok);
    logic [7:0] first;
    tx_busy = 1'b0;
    wait_send(ok);
    got = tx_data;
    if (!ok) return;
    first = tx_data;
    tx_busy = 1'b1;
    tick();
    tick();
    vectors++;
    if (tx_data !== first) begin
      miscompares++; $display("FAIL serve_hold: tx_data got %h exp %h", tx_data, first);
    end
    tx_busy = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    vectors++;
    if ({count, empty, full, tx_send, tx_data, overflow, timeout} !== {5'd0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL reset_state: cnt=%0d empty=%b full=%b send=%b data=%h ovf=%b tmo=%b exp 0/1/0/0/00/0/0",
               count, empty, full, tx_send, tx_data, overflow, timeout);
    end
    rst = 1'b0;
    tick();
    vectors++;
    if (tx_send !== 1'b0 || empty !== 1'b1) begin
      miscompares++; $display("FAIL reset_idle: send=%b empty=%b exp 0/1", tx_send, empty);
    end
  endtask

  task automatic test_single();
    logic [7:0] got;
    bit ok;
    wr_en = 1'b1; wr_data = 8'hA5;
    tick();                       // write accepted
    wr_en = 1'b0;
    vectors++;
    if (count !== 5'd1 || tx_send !== 1'b0) begin
      miscompares++; $display("FAIL single_e0: cnt=%0d send=%b exp 1/0", count, tx_send);
    end
    tick();
    vectors++;
    if (tx_send !== 1'b0) begin
      miscompares++; $display("FAIL single_e1: send=%b exp 0", tx_send);
    end
    tick();                       // two edges after the write
    vectors++;
    if (tx_send !== 1'b1 || tx_data !== 8'hA5) begin
      miscompares++; $display("FAIL single_e2: send=%b data=%h exp 1/a5", tx_send, tx_data);
    end
    tx_busy = 1'b1;
    tick();
    vectors++;
    if (tx_send !== 1'b0) begin
      miscompares++; $display("FAIL single_pulse_width: send=%b exp 0", tx_send);
    end
    tick();
    tick();
    tx_busy = 1'b0;
    tick();
    vectors++;
    if (count !== 5'd0 || empty !== 1'b1 || timeout !== 1'b0) begin
      miscompares++; $display("FAIL single_done: cnt=%0d empty=%b tmo=%b exp 0/1/0", count, empty, timeout);
    end
    // silence check: nothing else should be sent
    wait_send(ok);
    vectors++;
    if (ok) begin
      miscompares++; $display("FAIL single_dup: extra send data=%h exp none", tx_data);
    end
    got = 8'h00;
    if (got !== 8'h00) $display("unexpected");
  endtask

  task automatic test_overflow();
    logic [7:0] got;
    bit ok;
    tx_busy = 1'b1;               // hold the FSM in IDLE
    for (int i = 0; i < 17; i++) begin
      wr_en = 1'b1; wr_data = 8'(i);
      tick();
      if (i == 15) begin
        vectors++;
        if (full !== 1'b1 || count !== 5'd16 || overflow !== 1'b0) begin
          miscompares++; $display("FAIL ovf_full: full=%b cnt=%0d ovf=%b exp 1/16/0", full, count, overflow);
        end
      end
    end
    wr_en = 1'b0;
    vectors++;
    if (overflow !== 1'b1 || count !== 5'd16 || full !== 1'b1) begin
      miscompares++; $display("FAIL ovf_drop: ovf=%b cnt=%0d full=%b exp 1/16/1", overflow, count, full);
    end
    for (int i = 0; i < 16; i++) begin
      serve_one(got, ok);
      vectors++;
      if (!ok || got !== 8'(i)) begin
        miscompares++; $display("FAIL ovf_order[%0d]: got %h sent=%b exp %h", i, got, ok, 8'(i));
      end
      if (!ok) break;
    end
    vectors++;
    if (empty !== 1'b1 || overflow !== 1'b1) begin
      miscompares++; $display("FAIL ovf_drained: empty=%b ovf=%b exp 1/1", empty, overflow);
    end
  endtask

  task automatic test_clr_err();
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    vectors++;
    if (overflow !== 1'b0) begin
      miscompares++; $display("FAIL clr_ovf: ovf=%b exp 0", overflow);
    end
    tx_busy = 1'b1;
    for (int i = 0; i < 16; i++) begin
      wr_en = 1'b1; wr_data = 8'($urandom);
      tick();
    end
    clr_err = 1'b1;               // write to full FIFO in the same cycle
    tick();
    wr_en = 1'b0; clr_err = 1'b0;
    vectors++;
    if (overflow !== 1'b1 || count !== 5'd16) begin
      miscompares++; $display("FAIL clr_set_wins: ovf=%b cnt=%0d exp 1/16", overflow, count);
    end
    do_reset();
  endtask

  task automatic test_timeout();
    bit ok;
    tx_busy = 1'b0;
    wr_en = 1'b1; wr_data = 8'h3C;
    tick();
    wr_en = 1'b0;
    wait_send(ok);
    vectors++;
    if (!ok || tx_data !== 8'h3C) begin
      miscompares++; $display("FAIL tmo_first: sent=%b data=%h exp 1/3c", ok, tx_data);
    end
    for (int i = 1; i <= 5; i++) begin
      tick();
      if (i < 5) begin
        vectors++;
        if (tx_send !== 1'b0 || timeout !== 1'b0) begin
          miscompares++; $display("FAIL tmo_wait[%0d]: send=%b tmo=%b exp 0/0", i, tx_send, timeout);
        end
      end
    end
    vectors++;
    if (timeout !== 1'b1 || tx_send !== 1'b1 || tx_data !== 8'h3C) begin
      miscompares++; $display("FAIL tmo_retry: tmo=%b send=%b data=%h exp 1/1/3c", timeout, tx_send, tx_data);
    end
    tx_busy = 1'b1;
    tick();
    tick();
    tx_busy = 1'b0;
    tick();
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    vectors++;
    if (count !== 5'd0 || timeout !== 1'b0) begin
      miscompares++; $display("FAIL tmo_clear: cnt=%0d tmo=%b exp 0/0", count, timeout);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] got;
    bit ok;
    tx_busy = 1'b0;
    wr_en = 1'b1; wr_data = 8'h11;
    tick();
    wr_en = 1'b0;
    wait_send(ok);
    tx_busy = 1'b1;
    tick();
    tick();                       // now in WAIT_DONE
    tick();
    vectors++;
    if (count !== 5'd1) begin
      miscompares++; $display("FAIL b2b_pre: cnt=%0d exp 1", count);
    end
    tx_busy = 1'b0; wr_en = 1'b1; wr_data = 8'h55;
    tick();                       // pop and write on the same edge
    wr_en = 1'b0;
    vectors++;
    if (count !== 5'd1 || empty !== 1'b0) begin
      miscompares++; $display("FAIL b2b_count: cnt=%0d empty=%b exp 1/0", count, empty);
    end
    serve_one(got, ok);
    vectors++;
    if (!ok || got !== 8'h55) begin
      miscompares++; $display("FAIL b2b_next: got %h sent=%b exp 55", got, ok);
    end
    vectors++;
    if (count !== 5'd0) begin
      miscompares++; $display("FAIL b2b_end: cnt=%0d exp 0", count);
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] got;
    bit ok;
    tx_busy = 1'b0;
    wr_en = 1'b1; wr_data = 8'hAA;
    tick();
    wr_en = 1'b0;
    wait_send(ok);
    for (int i = 0; i < 5; i++) tick();   // let it time out once
    vectors++;
    if (timeout !== 1'b1 || tx_send !== 1'b1) begin
      miscompares++; $display("FAIL rstmid_tmo: tmo=%b send=%b exp 1/1", timeout, tx_send);
    end
    tx_busy = 1'b1;
    tick();
    tick();                       // WAIT_DONE
    for (int i = 0; i < 4; i++) begin
      wr_en = 1'b1; wr_data = 8'(8'hB0 + i);
      tick();
    end
    wr_en = 1'b0;
    vectors++;
    if (count !== 5'd5 || tx_data !== 8'hAA) begin
      miscompares++; $display("FAIL rstmid_pre: cnt=%0d data=%h exp 5/aa", count, tx_data);
    end
    #2 rst = 1'b1;                // between edges: must act immediately
    #1;
    vectors++;
    if ({count, tx_send, tx_data, overflow, timeout, empty} !== {5'd0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1}) begin
      miscompares++;
      $display("FAIL rstmid_async: cnt=%0d send=%b data=%h ovf=%b tmo=%b empty=%b exp 0/0/00/0/0/1",
               count, tx_send, tx_data, overflow, timeout, empty);
    end
    tick();
    rst = 1'b0;
    wr_en = 1'b1; wr_data = 8'h77;  // busy still high after reset
    tick();
    wr_en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      vectors++;
      if (tx_send !== 1'b0 || count !== 5'd1) begin
        miscompares++; $display("FAIL rstmid_hold[%0d]: send=%b cnt=%0d exp 0/1", i, tx_send, count);
      end
    end
    serve_one(got, ok);
    vectors++;
    if (!ok || got !== 8'h77) begin
      miscompares++; $display("FAIL rstmid_after: got %h sent=%b exp 77", got, ok);
    end
  endtask

  // Randomized traffic against a queue model of the FIFO.
  task automatic test_random();
    logic [7:0] mq[$];
    bit         movf = 1'b0;
    int         phase = 0;        // 0 idle, 1 send seen, 2 busy high
    int         dly = 0;
    int         hold = 0;
    bit         pop_pend;
    bit         acc;
    int         sent = 0;
    do_reset();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      vectors++;
      if (count !== 5'(mq.size()) || full !== (mq.size() == DEPTH) || empty !== (mq.size() == 0)
          || overflow !== movf || timeout !== 1'b0) begin
        miscompares++;
        $display("FAIL rnd_status@%0d: cnt=%0d full=%b empty=%b ovf=%b tmo=%b exp cnt=%0d ovf=%b tmo=0",
                 cyc, count, full, empty, overflow, timeout, mq.size(), movf);
      end
      if (tx_send === 1'b1) begin
        vectors++;
        if (phase != 0 || mq.size() == 0 || tx_data !== mq[0]) begin
          miscompares++;
          $display("FAIL rnd_send@%0d: data=%h phase=%0d exp %h in idle phase", cyc, tx_data, phase,
                   (mq.size() != 0) ? mq[0] : 8'h00);
        end
        if (phase == 0) begin
          phase = 1;
          dly = $urandom_range(0, 2);
          sent++;
        end
      end else if (phase != 0) begin
        vectors++;
        if (mq.size() == 0 || tx_data !== mq[0]) begin
          miscompares++; $display("FAIL rnd_hold@%0d: data=%h exp front of queue", cyc, tx_data);
        end
      end
      // transmitter behaviour
      pop_pend = 1'b0;
      if (phase == 1) begin
        if (dly == 0) begin
          tx_busy = 1'b1; phase = 2; hold = $urandom_range(2, 4);
        end else begin
          dly--;
        end
      end else if (phase == 2) begin
        hold--;
        if (hold == 0) begin
          tx_busy = 1'b0; pop_pend = 1'b1; phase = 0;
        end
      end
      // writer behaviour; the tail of the run only drains
      wr_en   = (cyc < 2500) ? ($urandom_range(0, 3) != 0) : 1'b0;
      wr_data = 8'($urandom);
      clr_err = ($urandom_range(0, 49) == 0);
      acc = wr_en && (mq.size() < DEPTH);
      if (wr_en && !acc) movf = 1'b1;
      else if (clr_err)  movf = 1'b0;
      tick();
      if (pop_pend) void'(mq.pop_front());
      if (acc) mq.push_back(wr_data);
    end
    wr_en = 1'b0; clr_err = 1'b0;
    vectors++;
    if (mq.size() != 0 || empty !== 1'b1 || sent < 50) begin
      miscompares++; $display("FAIL rnd_drain: left=%0d empty=%b sends=%0d exp 0/1/>=50", mq.size(), empty, sent);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_overflow();
    test_clr_err();
    test_timeout();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/tx_feeder.md
TX_FEEDER -- requirements
Module: tx_feeder

Interface
REQ-001 SHALL have parameter DEPTH, default 16, FIFO depth in bytes (power of 2, 2..256).
REQ-002 SHALL have parameter TIMEOUT, default 4, cycles to wait for tx_busy rise after a send pulse (2..255).
REQ-003 SHALL have port clk_s  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port wr_en  input  1  write strobe, one byte per high cycle.
REQ-006 SHALL have port wr_data  input  8  byte to enqueue.
REQ-007 SHALL have port full  output  1  high when count == DEPTH.
REQ-008 SHALL have port empty  output  1  high when count == 0.
REQ-009 SHALL have port count  output  log2(DEPTH)+1  number of bytes held, including the byte in transmission.
REQ-010 SHALL have port tx_send  output  1  send request to the serial transmitter.
REQ-011 SHALL have port tx_data  output  8  byte presented to the transmitter.
REQ-012 SHALL have port tx_busy  input  1  transmitter busy flag.
REQ-013 SHALL have port overflow  output  1  sticky: a write was dropped.
REQ-014 SHALL have port timeout  output  1  sticky: tx_busy failed to rise within TIMEOUT.
REQ-015 SHALL have port clr_err  input  1  synchronous clear of overflow and timeout.

Function
REQ-016 SHALL store bytes in a DEPTH-entry circular buffer; wr_ptr and rd_ptr wrap from DEPTH-1 to 0.
REQ-017 SHALL accept a write only when wr_en=1 and full=0; wr_en=1 with full=1 drops the byte and sets overflow, even if a pop occurs that cycle.
REQ-018 SHALL leave count unchanged on a simultaneous accepted write and pop.
REQ-019 SHALL use the FSM states IDLE, LOAD, SEND, WAIT_BUSY, WAIT_DONE.
REQ-020 IDLE: empty=0 and tx_busy=0 -> LOAD; otherwise stay in IDLE.
REQ-021 LOAD: register tx_data <= mem[rd_ptr] and clear the timeout counter -> SEND.
REQ-022 SEND: tx_send=1 for exactly this one cycle -> WAIT_BUSY.
REQ-023 WAIT_BUSY: tx_busy=1 -> WAIT_DONE; otherwise increment the timeout counter; on reaching TIMEOUT, set timeout and return to SEND (retry the same byte).
REQ-024 WAIT_DONE: tx_busy=0 -> pop (rd_ptr+1, count-1) and go to IDLE.
REQ-025 SHALL hold tx_data constant from the LOAD exit until the WAIT_DONE exit, because the transmitter samples it bit by bit.
REQ-026 SHALL keep tx_send=0 in every state other than SEND.
REQ-027 SHALL assert tx_send exactly 2 cycles after the edge on which a write is accepted into an empty FIFO while idle.
REQ-028 full, empty, count SHALL reflect the post-edge state; a byte stays counted until its pop.
REQ-029 clr_err=1 SHALL clear overflow and timeout, except that a set event in the same cycle wins.
REQ-030 SHALL emit bytes in write order, with no loss and no duplication apart from timeout retries.

Reset
REQ-031 rst=1 SHALL immediately force the following, regardless of clock:
- state=IDLE
- wr_ptr=0, rd_ptr=0, count=0
- tx_send=0, tx_data=0x00
- overflow=0, timeout=0, timeout counter=0
REQ-032 Buffer contents need no reset.
REQ-033 Reset mid-transfer SHALL discard all queued bytes.
REQ-034 After reset, the block SHALL stay in IDLE until tx_busy=0 before issuing a send.

Verification
REQ-035 Write 0xA5 into an empty, idle FIFO -> tx_send pulses one cycle 2 cycles later, with tx_data=0xA5. Busy rise then fall -> count=0, empty=1.
REQ-036 Write 17 bytes 0x00..0x10 back-to-back with tx_busy stuck 1 -> full=1 after 16 writes, 17th dropped, overflow=1. Release busy -> bytes 0x00..0x0F emitted in order.
REQ-037 Write 0x3C with tx_busy held 0 -> timeout=1 after 4 WAIT_BUSY cycles, second tx_send pulse, tx_data still 0x3C.
REQ-038 With count=1 in WAIT_DONE, write 0x55 on the same cycle tx_busy falls -> count stays 1; 0x55 is sent next.
REQ-039 Assert rst during WAIT_DONE with count=5 -> same cycle: count=0, tx_send=0, tx_data=0x00, all flags 0.
REQ-040 Pulse clr_err with overflow=1 -> overflow=0. clr_err together with a full-FIFO write -> overflow stays 1.
